// File: rtl/toggle_activity_counter.sv
// Per-net transition counter for switching-activity collection.
// Counts rising and falling edges per channel, with a req/ack read port and sticky overflow.
module toggle_activity_counter #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              C,
    input  logic              R,
    input  logic [N_CH-1:0]   sig_in,
    input  logic              enable,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_clr,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic              rd_err,
    output logic              any_ovf
);

    typedef enum logic {StIdle, StAck} rd_state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [N_CH-1:0]  s1_q, s2_q, prev_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic [1:0]       warm_q;
    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_ovf_q, rd_err_q, any_ovf_q;

    logic             accept;
    logic             addr_ok;
    logic             count_en;
    logic [N_CH-1:0]  toggle;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_ovf;

    assign toggle   = s2_q ^ prev_q;
    assign count_en = enable && (warm_q == 2'd3);
    assign addr_ok  = 32'(rd_addr) < N_CH;

    // Read FSM: ACK always returns to IDLE, so a request seen in ACK is dropped.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (rd_req) begin
                    state_d = StAck;
                    accept  = 1'b1;
                end
            end
            StAck: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(rd_addr) == i) begin
                sel_cnt = cnt_q[i];
                sel_ovf = ovf_q[i];
            end
        end
    end

    // A clear that coincides with a counted transition leaves 1 so the edge is not lost.
    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && addr_ok && rd_clr && (32'(rd_addr) == i)) begin
                cnt_d[i] = (toggle[i] && count_en) ? CntOne : '0;
                ovf_d[i] = 1'b0;
            end else if (toggle[i] && count_en) begin
                if (cnt_q[i] == CntMax) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            cnt_q     <= '{default: '0};
            ovf_q     <= '0;
            any_ovf_q <= 1'b0;
            warm_q    <= 2'd0;
            state_q   <= StIdle;
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            any_ovf_q <= |ovf_d;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
            state_q <= state_d;
            if (accept) begin
                rd_data_q <= addr_ok ? sel_cnt : '0;
                rd_ovf_q  <= addr_ok ? sel_ovf : 1'b0;
                rd_err_q  <= ~addr_ok;
            end
        end
    end

    assign rd_ack  = (state_q == StAck);
    assign rd_data = rd_data_q;
    assign rd_ovf  = rd_ovf_q;
    assign rd_err  = rd_err_q;
    assign any_ovf = any_ovf_q;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Scoreboard bench for toggle_activity_counter (4-bit counters to reach saturation quickly).
module tb_toggle_activity_counter;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 4;

    logic              C = 1'b0;
    logic              R = 1'b1;
    logic [N_CH-1:0]   sig_in = '0;
    logic              enable = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_clr = 1'b0;
    logic              rd_ack;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_ovf;
    logic              rd_err;
    logic              any_ovf;

    typedef struct packed {
        logic [CNT_W-1:0] data;
        logic             ovf;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_seen = 0;
    int   base;
    logic ack_prev = 1'b0;

    toggle_activity_counter #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .C      (C),
        .R      (R),
        .sig_in (sig_in),
        .enable (enable),
        .rd_req (rd_req),
        .rd_addr(rd_addr),
        .rd_clr (rd_clr),
        .rd_ack (rd_ack),
        .rd_data(rd_data),
        .rd_ovf (rd_ovf),
        .rd_err (rd_err),
        .any_ovf(any_ovf)
    );

    always #5 C = ~C;

    // Monitor: every ack pops one expectation; acks must never last two cycles.
    always @(negedge C) begin : monitor
        exp_t e;
        if (rd_ack) begin
            ack_seen++;
            checks++;
            if (ack_prev) begin
                failures++;
                $display("FAIL ack_width: rd_ack high on two consecutive cycles, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: rd_ack with empty scoreboard, data=%0d ovf=%0b err=%0b",
                         rd_data, rd_ovf, rd_err);
            end else begin
                e = exp_q.pop_front();
                if ({rd_data, rd_ovf, rd_err} !== e) begin
                    failures++;
                    $display("FAIL read: got data=%0d ovf=%0b err=%0b, required data=%0d ovf=%0b err=%0b",
                             rd_data, rd_ovf, rd_err, e.data, e.ovf, e.err);
                end
            end
        end
        ack_prev = rd_ack;
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic clr, input logic [CNT_W-1:0] d,
                      input logic o, input logic e);
        exp_q.push_back(exp_t'({d, o, e}));
        rd_addr = a;
        rd_clr  = clr;
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_clr = 1'b0;
        tick();
    endtask

    task automatic flip(input int ch, input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            sig_in[ch] = ~sig_in[ch];
            repeat (hold) tick();
        end
    endtask

    initial begin
        // Reset with all nets high: warm-up must hide the level
        sig_in = 4'hF;
        enable = 1'b1;
        R = 1'b1;
        repeat (3) tick();
        check("reset_ack", rd_ack, 0);
        check("reset_data", rd_data, 0);
        check("reset_ovf", rd_ovf, 0);
        check("reset_err", rd_err, 0);
        check("reset_any_ovf", any_ovf, 0);
        R = 1'b0;
        repeat (10) tick();
        for (int a = 0; a < 4; a++) rd(ADDR_W'(a), 1'b0, 4'd0, 1'b0, 1'b0);

        flip(1, 5, 3);
        repeat (3) tick();
        rd(4'd1, 1'b0, 4'd5, 1'b0, 1'b0);
        rd(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        enable = 1'b0;
        flip(2, 3, 3);
        repeat (4) tick();
        enable = 1'b1;
        repeat (3) tick();
        flip(2, 2, 3);
        repeat (3) tick();
        rd(4'd2, 1'b0, 4'd2, 1'b0, 1'b0);

        // Saturation: 17 transitions into a 4-bit counter
        flip(0, 17, 2);
        repeat (3) tick();
        check("any_ovf_set", any_ovf, 1);
        rd(4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
        rd(4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
        check("any_ovf_clr", any_ovf, 0);
        rd(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Clear on the same edge the channel counts
        flip(3, 2, 3);
        repeat (3) tick();
        rd(4'd3, 1'b0, 4'd2, 1'b0, 1'b0);
        sig_in[3] = ~sig_in[3];
        tick();
        tick();
        rd(4'd3, 1'b1, 4'd2, 1'b0, 1'b0);
        repeat (2) tick();
        rd(4'd3, 1'b0, 4'd1, 1'b0, 1'b0);

        rd(4'd4, 1'b0, 4'd0, 1'b0, 1'b1);
        rd(4'd15, 1'b1, 4'd0, 1'b0, 1'b1);
        rd(4'd1, 1'b0, 4'd5, 1'b0, 1'b0);

        // rd_req held four cycles: two accepted reads
        base = ack_seen;
        exp_q.push_back(exp_t'({4'd5, 1'b0, 1'b0}));
        exp_q.push_back(exp_t'({4'd5, 1'b0, 1'b0}));
        rd_addr = 4'd1;
        rd_req = 1'b1;
        repeat (4) tick();
        rd_req = 1'b0;
        tick();
        tick();
        check("b2b_acks", ack_seen - base, 2);

        // Reset during ACK
        exp_q.push_back(exp_t'({4'd5, 1'b0, 1'b0}));
        rd_addr = 4'd1;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        R = 1'b1;
        tick();
        check("abort_ack", rd_ack, 0);
        check("abort_data", rd_data, 0);
        R = 1'b0;
        repeat (6) tick();
        for (int a = 0; a < 4; a++) rd(ADDR_W'(a), 1'b0, 4'd0, 1'b0, 1'b0);
        check("post_reset_any_ovf", any_ovf, 0);

        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
